// File: rtl/monolith_pkg.sv
// Shared types, constants and Mersenne-31 field helpers for the Monolith-31
// round datapath. Every helper maps canonical inputs to canonical outputs.
package monolith_pkg;

  localparam int WIDTH = 31;
  localparam int T     = 16;
  localparam int NBARS = 8;

  localparam logic [30:0] P = 31'h7FFFFFFF;

  // First row of the circulant Concrete matrix; row i is this row rotated right by i.
  localparam logic [4:0] MDS_ROW [0:15] = '{
    5'd23, 5'd8,  5'd13, 5'd10, 5'd7,  5'd6,  5'd21, 5'd8,
    5'd2,  5'd12, 5'd26, 5'd24, 5'd22, 5'd11, 5'd14, 5'd21
  };

  typedef logic [WIDTH-1:0] felem_t;
  typedef felem_t state_t [T];

  // Repeated hi/lo folding: 2^31 == 1 (mod p). Four folds bring any 64-bit
  // value below 2^31. The single value p itself is then mapped to 0.
  function automatic felem_t mod_reduce(input logic [63:0] v);
    logic [63:0] acc;
    acc = v;
    for (int k = 0; k < 4; k++) begin
      acc = {31'd0, acc[63:31]} + {33'd0, acc[30:0]};
    end
    if (acc[30:0] == P) return '0;
    return acc[30:0];
  endfunction

  function automatic felem_t mod_add(input felem_t a, input felem_t b);
    return mod_reduce({33'd0, a} + {33'd0, b});
  endfunction

  function automatic felem_t mod_mul(input felem_t a, input felem_t b);
    logic [61:0] pr;
    pr = {31'd0, a} * {31'd0, b};
    return mod_reduce({2'd0, pr});
  endfunction

  function automatic felem_t mod_sqr(input felem_t a);
    return mod_mul(a, a);
  endfunction

  // 8-bit chi-style S-box: rotl1(y ^ (rotl1(~y) & rotl2(y) & rotl3(y))).
  function automatic logic [7:0] s8(input logic [7:0] y);
    logic [7:0] n;
    logic [7:0] t;
    n = ~y;
    t = y ^ ({n[6:0], n[7]} & {y[5:0], y[7:6]} & {y[4:0], y[7:5]});
    return {t[6:0], t[7]};
  endfunction

  // 7-bit chi-style S-box for the top limb: rotl1(y ^ (rotl1(~y) & rotl2(y))).
  function automatic logic [6:0] s7(input logic [6:0] y);
    logic [6:0] n;
    logic [6:0] t;
    n = ~y;
    t = y ^ ({n[5:0], n[6]} & {y[4:0], y[6:5]});
    return {t[5:0], t[6]};
  endfunction

  // Bars on one element: limbs are substituted in place. All-ones limbs are
  // fixed points, so p maps to p and canonical stays canonical.
  function automatic felem_t bar(input felem_t x);
    return {s7(x[30:24]), s8(x[23:16]), s8(x[15:8]), s8(x[7:0])};
  endfunction

endpackage

// File: rtl/monolith_round_core_mersenne_mul.sv
// Combinational 31x31 multiply with Mersenne-31 reduction; used for the
// Bricks squarings.
module mersenne_mul
  import monolith_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod
);

  assign prod = mod_mul(a, b);

endmodule

// File: rtl/monolith_round_core.sv
// One Monolith-31 round (Bars, Bricks, Concrete, round constants) as a single
// combinational cloud followed by one output register with a valid flag.
// Sizes come from monolith_pkg (WIDTH=31, T=16, NBARS=8).
module monolith_round_core
  import monolith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] state_in  [0:T-1],
  input  logic [WIDTH-1:0] rc_in     [0:T-1],
  output logic             out_valid,
  output logic [WIDTH-1:0] state_out [0:T-1]
);

  felem_t bars_b   [T];
  felem_t sq       [T-1];
  felem_t bricks_y [T];
  felem_t round_nx [T];

  felem_t state_p1 [T];
  logic   vld_p1;

  // Bars: S-box the leading NBARS elements, pass the rest through.
  always_comb begin
    for (int i = 0; i < T; i++) begin
      bars_b[i] = (i < NBARS) ? bar(state_in[i]) : state_in[i];
    end
  end

  // Squares of b[0..14] feed the Feistel additions of Bricks.
  for (genvar g = 1; g < T; g++) begin : g_sq
    mersenne_mul u_sq (
      .a    (bars_b[g-1]),
      .b    (bars_b[g-1]),
      .prod (sq[g-1])
    );
  end

  // Bricks: every square uses the pre-Bricks neighbour, so no ripple.
  always_comb begin
    bricks_y[0] = bars_b[0];
    for (int i = 1; i < T; i++) begin
      bricks_y[i] = mod_add(bars_b[i], sq[i-1]);
    end
  end

  // Concrete plus round constants. Coefficients are < 32 so sixteen terms
  // stay below 2^40; one reduction per output element suffices.
  always_comb begin
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < T; i++) begin
      acc = '0;
      for (int j = 0; j < T; j++) begin
        acc = acc + ({59'd0, MDS_ROW[(j - i + T) % T]} * {33'd0, bricks_y[j]});
      end
      round_nx[i] = mod_add(mod_reduce(acc), rc_in[i]);
    end
  end

  // ---- stage p1: output register; holds its value when no new input ----
  // Capture the round result on valid input; asynchronous clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < T; i++) state_p1[i] <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < T; i++) state_p1[i] <= round_nx[i];
      end
    end
  end

  assign out_valid = vld_p1;

  for (genvar g = 0; g < T; g++) begin : g_out
    assign state_out[g] = state_p1[g];
  end

endmodule

// File: tb/tb_monolith_round_core.sv
// Scoreboard bench for monolith_round_core: the stimulus process pushes the
// expected round output, a negedge monitor pops and compares.
module tb_monolith_round_core;

  typedef logic [15:0][30:0] pvec_t;

  localparam longint unsigned PM = 64'h7FFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [30:0] state_in  [0:15];
  logic [30:0] rc_in     [0:15];
  logic        out_valid;
  logic [30:0] state_out [0:15];

  int checks = 0;
  int errors = 0;

  pvec_t exp_q [$];
  pvec_t last_exp;

  int mds [16] = '{23, 8, 13, 10, 7, 6, 21, 8, 2, 12, 26, 24, 22, 11, 14, 21};

  monolith_round_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state_in  (state_in),
    .rc_in     (rc_in),
    .out_valid (out_valid),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic n-bit chi S-box written bit by bit from its definition.
  function automatic longint unsigned chi(input longint unsigned y, input int n);
    logic [7:0] yb;
    logic [7:0] t;
    logic [7:0] o;
    logic       c;
    yb = y[7:0];
    t  = '0;
    o  = '0;
    for (int i = 0; i < n; i++) begin
      c = (n == 8) ? yb[(i + n - 3) % n] : 1'b1;
      t[i] = yb[i] ^ (~yb[(i + n - 1) % n] & yb[(i + n - 2) % n] & c);
    end
    for (int i = 0; i < n; i++) o[i] = t[(i + n - 1) % n];
    return {56'd0, o};
  endfunction

  // Reference round using plain modular arithmetic on 64-bit integers.
  function automatic pvec_t model(input pvec_t s, input pvec_t r);
    longint unsigned b [16];
    longint unsigned y [16];
    longint unsigned x, z;
    pvec_t o;
    for (int i = 0; i < 16; i++) begin
      x = {33'd0, s[i]};
      if (i < 8)
        b[i] = chi(x % 256, 8) + 256 * chi((x / 256) % 256, 8)
             + 65536 * chi((x / 65536) % 256, 8) + 16777216 * chi(x / 16777216, 7);
      else
        b[i] = x;
    end
    y[0] = b[0];
    for (int i = 1; i < 16; i++) y[i] = (b[i] + (b[i-1] * b[i-1]) % PM) % PM;
    for (int i = 0; i < 16; i++) begin
      z = 0;
      for (int j = 0; j < 16; j++) z = (z + longint'(mds[(j - i + 16) % 16]) * y[j]) % PM;
      z = (z + {33'd0, r[i]}) % PM;
      o[i] = z[30:0];
    end
    return o;
  endfunction

  function automatic logic [30:0] rand_elem();
    logic [30:0] v;
    case ($urandom_range(0, 7))
      0: v = 31'h7FFFFFFE;
      1: v = 31'd0;
      2: v = 31'd1;
      3: v = 31'h7FFFFFFD;
      default: begin
        v = 31'($urandom());
        if (v == 31'h7FFFFFFF) v = '0;
      end
    endcase
    return v;
  endfunction

  function automatic pvec_t pack_out();
    pvec_t v;
    for (int i = 0; i < 16; i++) v[i] = state_out[i];
    return v;
  endfunction

  task automatic report(input string name, input pvec_t got, input pvec_t exp);
    for (int i = 0; i < 16; i++) begin
      if (got[i] !== exp[i]) begin
        $display("FAIL %s elem %0d got %h want %h", name, i, got[i], exp[i]);
        break;
      end
    end
  endtask

  task automatic send(input pvec_t s, input pvec_t r, input pvec_t e);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      state_in[i] = s[i];
      rc_in[i]    = r[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        state_in[i] = rand_elem();
        rc_in[i]    = rand_elem();
      end
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (out_valid !== 1'b0 || pack_out() !== '0) begin
      errors++;
      $display("FAIL %s out_valid %b state_out[0] %h want 0/0", name, out_valid, state_out[0]);
    end
  endtask

  // Monitor: pop on every valid output, otherwise the output must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got valid with empty scoreboard, want none");
        end else begin
          last_exp = exp_q.pop_front();
          if (pack_out() !== last_exp) begin
            errors++;
            report("round_out", pack_out(), last_exp);
          end
        end
      end else begin
        checks++;
        if (pack_out() !== last_exp) begin
          errors++;
          report("hold", pack_out(), last_exp);
        end
      end
    end
  end

  initial begin
    pvec_t s, r, e;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    last_exp = '0;
    for (int i = 0; i < 16; i++) begin
      state_in[i] = rand_elem();
      rc_in[i]    = rand_elem();
    end

    // Reset held with active random inputs.
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_state");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(3);

    // All-zero state: output equals the round constants.
    s = '0;
    for (int i = 0; i < 16; i++) r[i] = 31'(i);
    send(s, r, r);

    // Only x[15]=1: output is the last column of the circulant.
    s = '0; s[15] = 31'd1; r = '0;
    for (int i = 0; i < 16; i++) e[i] = 31'(mds[(15 - i + 16) % 16]);
    send(s, r, e);

    // Only x[0]=1: S(1)=2 then y[1]=4.
    s = '0; s[0] = 31'd1;
    for (int i = 0; i < 16; i++)
      e[i] = 31'(2 * mds[(16 - i) % 16] + 4 * mds[(17 - i) % 16]);
    send(s, r, e);
    idle(2);

    // Everything at p-1.
    for (int i = 0; i < 16; i++) begin
      s[i] = 31'h7FFFFFFE;
      r[i] = 31'h7FFFFFFE;
    end
    send(s, r, model(s, r));

    // Fixed 16-element vector.
    for (int i = 0; i < 16; i++) begin
      s[i] = 31'((longint'(i + 1) * 64'h0123_4567) % PM);
      r[i] = 31'((longint'(i + 3) * 64'h0765_4321) % PM);
    end
    send(s, r, model(s, r));
    idle(1);

    // Three back-to-back inputs then idle: output holds the last result.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        s[i] = rand_elem();
        r[i] = rand_elem();
      end
      send(s, r, model(s, r));
    end
    idle(3);

    // Random traffic with random gaps.
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 16; i++) begin
        s[i] = rand_elem();
        r[i] = rand_elem();
      end
      send(s, r, model(s, r));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    // Reset in the middle of a stream clears outputs immediately.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        s[i] = rand_elem();
        r[i] = rand_elem();
      end
      send(s, r, model(s, r));
    end
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    last_exp = '0;
    #1;
    check_cleared("midstream_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) begin
      s[i] = rand_elem();
      r[i] = rand_elem();
    end
    send(s, r, model(s, r));
    idle(1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/monolith_round_core.md
Name: monolith_round_core

Overview:
- One full Monolith-31 permutation round over the Mersenne-31 field (p = 2^31-1) on a 16-element state.
- Sequence: Bars (8-bit/7-bit chi S-box on limbs of elements 0..7), Bricks (Type-3 Feistel squaring), Concrete (16x16 circulant MDS multiply), then round-constant addition.
- Registered single-stage core with valid qualifier; the permutation controller instantiates it and iterates rounds, supplying the round constants for each round.

Parameters:
- WIDTH, 31, field element width.
- T, 16, state size in elements.
- NBARS, 8, number of leading elements passed through Bars.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  in  1  state_in/rc_in valid this cycle.
- state_in  in  T x WIDTH (unpacked [0:15])  input state; each element is canonical (< p).
- rc_in  in  T x WIDTH  round constants for this round; each element is canonical (< p).
- out_valid  out  1  state_out holds a new result.
- state_out  out  T x WIDTH (unpacked [0:15])  round output, canonical (< p).

Behaviour:
- Reset: out_valid=0 and all state_out elements=0, asynchronously on rst_n low.
- Latency is 1 cycle. If in_valid is high at edge k, then state_out=F(state_in,rc_in) and out_valid=1 after edge k.
- When in_valid is low at an edge, out_valid=0 and state_out holds its previous value.
- No backpressure; a new input is accepted every cycle.
- Bars, applied to x[0..7]:
  - Split x into limbs: L0=x[7:0], L1=x[15:8], L2=x[23:16], L3=x[30:24] (7 bits).
  - 8-bit limb: S8(y) = rotl1( y ^ (rotl1(~y) & rotl2(y) & rotl3(y)) ).
  - 7-bit limb: S7(y) = rotl1( y ^ (rotl1(~y) & rotl2(y)) ).
  - Reassemble the limbs in the same positions.
  - Elements x[8..15] pass through Bars unchanged.
  - The S-box maps 0x7FFFFFFF to itself, so canonical inputs give canonical outputs; no reduction is needed after Bars.
- Bricks, computed from the post-Bars values b:
  - y[0]=b[0].
  - y[i]=(b[i] + b[i-1]^2) mod p for i=1..15. All squares use the pre-Bricks values.
- Concrete: z[i] = sum over j of MDS_ROW[(j-i) mod 16] * y[j] mod p.
  - MDS_ROW = {23,8,13,10,7,6,21,8,2,12,26,24,22,11,14,21}.
  - All coefficients are < 32, so a shift-add implementation is acceptable.
- Output: state_out[i] = (z[i] + rc_in[i]) mod p.
- Mersenne reduction rule:
  - Fold high bits into low bits: hi*2^31+lo -> hi+lo. Repeat the fold until the value is < 2^31.
  - Then map 2^31-1 to 0. Result is always in [0, p-1].
- Reset asserted mid-operation: the pending result is discarded and the outputs are cleared.

Decomposition:
- Package monolith_pkg: P=31'h7FFFFFFF, WIDTH, T, NBARS, MDS_ROW constant, typedef felem_t (logic[30:0]), typedef state_t (felem_t[T]).
- Package functions: mod_add, mod_mul/mod_sqr with Mersenne folding, s8, s7, bar.
- One sub-module, mersenne_mul (31x31 multiply plus reduce), instantiated 15x in Bricks (squares).
- Everything else is combinational logic inside monolith_round_core, followed by the output register.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0 and all state_out=0; release with in_valid=0 -> outputs stay 0.
- All-zero state, rc_in[i]=i, in_valid=1 -> next cycle out_valid=1 and state_out[i]=i.
- state_in[15]=1, all others 0, rc=0 -> state_out[i]=MDS_ROW[(15-i) mod 16], i.e. out[0]=21, out[1]=14, ..., out[15]=23.
- Bars check: state_in[0]=1, others 0, rc=0:
  - S(1)=2, so b[0]=2 and Bricks gives y[1]=4.
  - Required output: state_out[i] = 2*MDS_ROW[(0-i) mod 16] + 4*MDS_ROW[(1-i) mod 16] mod p; for i=0 this is 46+32=78.
- Wrap and reduction: state_in[i]=p-1 for all i, rc[i]=p-1 -> every state_out element < p and matches a golden software model. Also cover the 16-element vector input_vec_16 with its golden output file.
- Streaming: in_valid high for 3 consecutive cycles with different vectors, then low -> 3 consecutive correct outputs with out_valid=1, then out_valid=0 with the last value held. Assert rst_n mid-stream -> outputs clear immediately.
